// File: rtl/sequence_generator.sv
// sequence_generator: serialises the low LEN bits of a captured pattern MSB-first, REPEAT+1 times, then pulses DONE
module sequence_generator #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [W-1:0] i_pattern,
    input  logic [3:0]   i_len,
    input  logic [3:0]   i_repeat,
    output logic         o_x,
    output logic         o_valid,
    output logic         o_busy,
    output logic         o_done
);
    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
    localparam logic [3:0] WL = 4'(W);
    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_pat;
    logic [3:0]   r_len, r_rep, r_bit;
    logic         r_x;
    logic [3:0]   w_len_eff, w_bit_nxt, w_rep_nxt;
    logic [15:0]  w_in_ext, w_pat_ext;
    logic         w_accept, w_x_nxt;
    assign w_len_eff = (i_len > WL) ? WL : i_len;
    assign w_in_ext  = 16'(i_pattern);
    assign w_pat_ext = 16'(r_pat);
    assign w_accept  = (r_state == IDLE) && i_start && !i_abort && (i_len != 4'd0);
    assign o_x       = r_x;
    assign o_valid   = (r_state == SEND);
    assign o_busy    = (r_state == SEND);
    assign o_done    = (r_state == FIN);
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end
    // next state, next bit/repetition counters and next serial bit; r_bit always indexes the bit on X
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_rep_nxt   = r_rep;
        w_x_nxt     = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = 4'd0;
            w_rep_nxt   = 4'd0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    w_state_nxt = SEND;
                    w_bit_nxt   = w_len_eff - 4'd1;
                    w_rep_nxt   = i_repeat;
                    w_x_nxt     = w_in_ext[w_len_eff - 4'd1];
                end
                SEND: if (r_bit != 4'd0) begin
                    w_bit_nxt = r_bit - 4'd1;
                    w_x_nxt   = w_pat_ext[r_bit - 4'd1];
                end else if (r_rep != 4'd0) begin
                    w_rep_nxt = r_rep - 4'd1;
                    w_bit_nxt = r_len - 4'd1;
                    w_x_nxt   = w_pat_ext[r_len - 4'd1];
                end else begin
                    w_state_nxt = FIN;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    // captured transmission parameters, frozen for the whole transmission
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat <= '0;
            r_len <= 4'd0;
        end else if (w_accept) begin
            r_pat <= i_pattern;
            r_len <= w_len_eff;
        end
    end
    // counters and registered serial output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit <= 4'd0;
            r_rep <= 4'd0;
            r_x   <= 1'b0;
        end else begin
            r_bit <= w_bit_nxt;
            r_rep <= w_rep_nxt;
            r_x   <= w_x_nxt;
        end
    end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed and random checks of sequence_generator against a bit-queue reference model
module tb_sequence_generator;
    localparam int W = 8;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [3:0]   len = 4'd0, rep = 4'd0;
    logic         o_x, o_valid, o_busy, o_done;
    int           tests = 0, fails = 0;
    bit           q[$];
    bit           done_exp = 1'b0;
    logic [31:0]  hist = '0;
    int           hn = 0, dn = 0, busy_cnt = 0;

    sequence_generator #(.W(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_pattern(pattern), .i_len(len), .i_repeat(rep),
        .o_x(o_x), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic ev = q.size() > 0;
        logic ex = ev ? logic'(q[0]) : 1'b0;
        chk({tag, ".valid"}, 32'(o_valid), 32'(ev));
        chk({tag, ".x"},     32'(o_x),     32'(ex));
        chk({tag, ".busy"},  32'(o_busy),  32'(ev));
        chk({tag, ".done"},  32'(o_done),  32'(done_exp));
        if (o_valid) begin
            hist = {hist[30:0], o_x};
            hn++;
        end
        if (o_done) dn++;
        if (o_busy) busy_cnt++;
    endtask

    // reference: the queue holds every bit still to appear on X, front = bit currently shown
    task automatic model_edge();
        if (abort) begin
            q.delete();
            done_exp = 1'b0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
            done_exp = (q.size() == 0);
        end else if (done_exp) begin
            done_exp = 1'b0;
        end else if (start && len != 0) begin
            int l = (int'(len) > W) ? W : int'(len);
            for (int r = 0; r <= int'(rep); r++)
                for (int i = l - 1; i >= 0; i--) q.push_back(pattern[i]);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic s, input logic a, input logic [W-1:0] p, input logic [3:0] l, input logic [3:0] r);
        start = s; abort = a; pattern = p; len = l; rep = r;
    endtask

    task automatic clr();
        hist = '0; hn = 0; dn = 0; busy_cnt = 0;
    endtask

    initial begin
        #2;
        check_outputs("reset");
        #5 rst_n = 1'b1;
        cyc("idle");
        clr();
        drive(1, 0, 8'h0D, 4'd4, 4'd0);
        cyc("t28");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (6) cyc("t28");
        chk("t28.bits", hist[3:0], 32'hD);
        chk("t28.nbits", 32'(hn), 32'd4);
        chk("t28.ndone", 32'(dn), 32'd1);
        clr();
        drive(1, 0, 8'h05, 4'd3, 4'd2);
        cyc("t29");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (11) cyc("t29");
        chk("t29.bits", hist[8:0], 32'b101101101);
        chk("t29.nbits", 32'(hn), 32'd9);
        chk("t29.busy", 32'(busy_cnt), 32'd9);
        chk("t29.ndone", 32'(dn), 32'd1);
        clr();
        drive(1, 0, 8'hFF, 4'd0, 4'd3);
        repeat (4) cyc("len0");
        chk("len0.activity", 32'(hn + dn + busy_cnt), 32'd0);
        clr();
        drive(1, 0, 8'hA5, 4'd12, 4'd0);
        cyc("len12");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (10) cyc("len12");
        chk("len12.bits", hist[7:0], 32'hA5);
        chk("len12.nbits", 32'(hn), 32'd8);
        clr();
        drive(1, 0, 8'h0D, 4'd4, 4'd0);
        cyc("restart");
        drive(1, 0, 8'hF2, 4'd7, 4'd3);
        repeat (3) cyc("restart");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (4) cyc("restart");
        chk("restart.bits", hist[3:0], 32'hD);
        chk("restart.ndone", 32'(dn), 32'd1);
        clr();
        drive(1, 0, 8'hFF, 4'd8, 4'd0);
        cyc("abort");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (2) cyc("abort");
        abort = 1'b1;
        cyc("abort");
        abort = 1'b0;
        repeat (10) cyc("abort");
        chk("abort.nbits", 32'(hn), 32'd3);
        chk("abort.ndone", 32'(dn), 32'd0);
        clr();
        drive(1, 1, 8'hFF, 4'd4, 4'd0);
        repeat (3) cyc("startabort");
        chk("startabort.busy", 32'(busy_cnt), 32'd0);
        clr();
        drive(1, 0, 8'hFF, 4'd8, 4'd1);
        cyc("rst");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (2) cyc("rst");
        #1 rst_n = 1'b0;
        q.delete();
        done_exp = 1'b0;
        #1 check_outputs("rst.async");
        #1 rst_n = 1'b1;
        repeat (3) cyc("rst.idle");
        clr();
        drive(1, 0, 8'h0D, 4'd4, 4'd0);
        cyc("rst.new");
        drive(0, 0, 8'h00, 4'd0, 4'd0);
        repeat (6) cyc("rst.new");
        chk("rst.bits", hist[3:0], 32'hD);
        chk("rst.ndone", 32'(dn), 32'd1);
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, W'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
            cyc("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
